bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the per-digit seven-segment decoders. It accepts an unsigned binary value under a start/ready handshake and runs a shift-add-3 (double-dabble) conversion, one bit per clock. It presents a registered, packed BCD digit bus whose nibbles each drive one decoder's `bcd` input. Nibble `4'hF` is used as the blank code; the decoder turns all segments off for any nibble above 9.

## Interface
Parameters:
- `WIDTH`, 14: width of the binary input. Allowed range is 4 to 17.
- `DIGITS`, 4: number of BCD digits produced. Allowed range is 1 to 5.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `value_in`  in  WIDTH  unsigned binary value; sampled only on the edge that accepts `start`.
- `start`  in  1  conversion request; honoured only while `ready`=1.
- `ready`  out  1  high in IDLE (combinational decode of state).
- `done`  out  1  registered; one-cycle pulse when `bcd_out` and `overflow` update.
- `bcd_out`  out  4*DIGITS  registered packed digits; bits [3:0] are the least significant digit. Held between conversions.
- `overflow`  out  1  registered; high when the last accepted value was greater than 10^DIGITS−1. Held until the next `done`.

## Operation
- State machine with three states: IDLE, CONVERT, DONE.
- IDLE:
  - `start`=1 at an edge causes capture of `value_in` into the shift register.
  - The BCD scratch register is cleared to 0.
  - The bit counter is loaded with WIDTH.
  - The overflow compare against 10^DIGITS−1 is registered into an internal flag.
  - Next state is CONVERT.
- CONVERT, each edge:
  - Every scratch nibble ≥5 has 3 added.
  - The combined {scratch, shift register} is shifted left by 1.
  - The counter decrements.
  - When the counter reaches 1 before the edge, next state is DONE. This gives exactly WIDTH shift edges.
- DONE, one edge:
  - The scratch register is copied to `bcd_out`.
  - The internal flag is copied to `overflow`.
  - `done` is set to 1.
  - Next state is IDLE.
- Overflow result: `bcd_out` is forced to all digits `4'hF` (blank) and `overflow`=1. Scratch contents are discarded.
- `start` while not `ready` is ignored. It is not queued, and `value_in` is not sampled.
- The scratch register is DIGITS*4 bits wide; add-3 applies to all DIGITS nibbles. Bits shifted out of the top digit are discarded, which only occurs on overflow and is masked by the overflow forcing.
- Reset values: state IDLE (so `ready`=1), `done`=0, `overflow`=0, `bcd_out` all `4'hF` (display blank), counter 0, shift and scratch registers 0.
- Reset mid-conversion: the conversion is abandoned immediately, outputs take their reset values, and no `done` pulse follows.

## Timing
- Accept edge k (IDLE, `start`=1) leads to CONVERT edges k+1 through k+WIDTH, then the DONE edge k+WIDTH+1.
- After edge k+WIDTH+1: `done`=1, and `bcd_out`/`overflow` carry the new result. `ready`=1 in the same cycle, since the state is IDLE.
- `done` returns to 0 at the next edge.
- Total latency from the accept edge to the `done` edge is WIDTH+1 cycles; the default is 15.
- Back-to-back operation: holding `start`=1 re-accepts on the edge after `done` goes high. Throughput is one conversion per WIDTH+2 cycles.
- `ready` falls combinationally after the accept edge and stays low for WIDTH+1 cycles.
- `bcd_out` never changes except on the DONE edge or at reset.

## Configuration
- `BIN_TO_BCD_LZ_BLANK_EN`, defined: on the DONE edge, every leading zero digit above the least significant digit is written as `4'hF` (blanked).
  - Digit 0 is always shown.
  - Example: 42 gives `16'hFF42`; 0 gives `16'hFFF0`.
  - Overflow forcing takes precedence.
- Undefined: zeros are shown. Example: 42 gives `16'h0042`.
- Latency and handshake are identical in both builds.

## Test plan
Defaults throughout: WIDTH=14, DIGITS=4.
- Reset release → `bcd_out`=`16'hFFFF`, `overflow`=0, `done`=0, `ready`=1.
- Accept 1234 → `done` exactly 15 cycles after the accept edge, `bcd_out`=`16'h1234`, `overflow`=0, single-cycle `done`.
- Accept 9999, then 0 back-to-back with `start` held → `16'h9999`, then `16'h0000` (macro off) or `16'hFFF0` (macro on), with `done` pulses 16 cycles apart.
- Accept 10000 → `overflow`=1, `bcd_out`=`16'hFFFF`. Then accept 7 → `overflow`=0, `bcd_out`=`16'h0007` or `16'hFFF7`.
- Pulse `start` with `value_in`=55 during CONVERT of 321 → ignored; result 321, no extra `done`.
- Assert `reset` at cycle 6 of a conversion of 8888 → immediate reset values, no `done` for 15+ cycles. A subsequent accept of 8888 then yields `16'h8888`.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding per-digit seven-segment decoders.
// Optional leading-zero blanking is enabled by defining BIN_TO_BCD_LZ_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value_in,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [31:0] max_bcd(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < digits; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam logic [31:0] MAX_VAL = max_bcd(DIGITS);
  localparam logic [BCD_W-1:0] BLANK_ALL = {DIGITS{4'hF}};

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

`ifdef BIN_TO_BCD_LZ_BLANK_EN
  // Blank zero digits from the top down until the first non-zero; digit 0 always shown.
  function automatic logic [BCD_W-1:0] lz_blank(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = d;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && d[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;
  logic [BCD_W-1:0] result;
  logic             ovf_flag;

  assign ready = (state == ST_IDLE);

  always_comb begin
    scratch_adj = '0;
    for (int i = 0; i < DIGITS; i++) scratch_adj[4*i +: 4] = add3(scratch[4*i +: 4]);
  end

  always_comb begin
    result = scratch;
`ifdef BIN_TO_BCD_LZ_BLANK_EN
    result = lz_blank(scratch);
`endif
    if (ovf_flag) result = BLANK_ALL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      scratch  <= '0;
      ovf_flag <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= BLANK_ALL;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg    <= value_in;
            scratch  <= '0;
            cnt      <= CNT_W'(WIDTH);
            ovf_flag <= (32'(value_in) > MAX_VAL);
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          // Top-digit carry-out is dropped; it only happens on overflow, which is masked later.
          {scratch, shreg} <= {scratch_adj, shreg} << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd_out  <= result;
          overflow <= ovf_flag;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed vectors, queued expectations, decoupled done monitor.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = WIDTH + 1;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] value_in = '0;
  logic        start = 1'b0;
  logic        ready;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .start(start),
    .ready(ready), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bcd_out), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("ready_at_done", 32'(ready), 32'd1);
      end
    end
  end

  task automatic accept(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                        input bit push, output int k);
    int i;
    @(negedge clk);
    i = 0;
    while (!ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    value_in = v;
    start    = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    if (push) sb.push_back('{bcd: eb, ovf: eo, cyc: k + LAT});
    chk("ready_after_accept", 32'(ready), 32'd0);
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() > 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    logic [15:0] exp0, exp7;
`ifdef BIN_TO_BCD_LZ_BLANK_EN
    exp0 = 16'hFFF0;
    exp7 = 16'hFFF7;
`else
    exp0 = 16'h0000;
    exp7 = 16'h0007;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);

    accept(14'd1234, 16'h1234, 1'b0, 1'b1, k);
    drain();

    // Back-to-back with start held: second accept lands on the edge after done.
    accept(14'd9999, 16'h9999, 1'b0, 1'b1, k);
    start    = 1'b1;
    value_in = 14'd0;
    sb.push_back('{bcd: exp0, ovf: 1'b0, cyc: k + LAT + 1 + LAT});
    while (cyc < k + LAT + 1) @(posedge clk);
    #1;
    chk("b2b_ready_low", 32'(ready), 32'd0);
    start = 1'b0;
    drain();

    accept(14'd10000, 16'hFFFF, 1'b1, 1'b1, k);
    drain();
    accept(14'd7, exp7, 1'b0, 1'b1, k);
    drain();

    // Start during CONVERT must be ignored.
    accept(14'd321, 16'h0321, 1'b0, 1'b1, k);
`ifdef BIN_TO_BCD_LZ_BLANK_EN
    sb[sb.size()-1].bcd = 16'hF321;
`endif
    repeat (3) @(posedge clk);
    #1;
    value_in = 14'd55;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    // Reset mid-conversion: outputs return to reset values, no done follows.
    accept(14'd8888, 16'h8888, 1'b0, 1'b0, k);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_hold_bcd", 32'(bcd_out), 32'hFFFF);

    accept(14'd8888, 16'h8888, 1'b0, 1'b1, k);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
